// File: rtl/multdiv_unit.sv
// Sequential signed multiplier/divider for the execute stage.
// Multiply: radix-2 Booth, one step per clock. Divide: restoring division on
// operand magnitudes, one quotient bit per clock, sign applied at the end.
// Each op spends WIDTH iteration cycles (busy=1) followed by one finalise
// cycle (busy=0) that forms the result and exception. The result lands in
// the registered outputs on entry to DONE, which pulses data_resultRDY.
// That gives a fixed start-to-RDY latency of WIDTH+1 edges.
//
// Handshake: a start (ctrl_MULT or ctrl_DIV) is accepted on any rising edge,
// in any state. A start that arrives while an op is in flight aborts that op
// silently: no data_resultRDY is produced for it. data_resultRDY is a
// single-cycle pulse, and data_result/data_exception are valid while it is
// high. Both outputs then hold until the next op completes. If both start
// strobes are high on the same edge, the multiply is taken.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // Multiply: acc_hi/acc_lo/booth_q form the Booth shift register.
    // Divide:   acc_hi holds the partial remainder, and acc_lo shifts the
    //           dividend out while the quotient shifts in.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             booth_q;
    logic [WIDTH-1:0] op_m;      // multiplicand, or divisor magnitude
    logic             neg_q;     // quotient sign
    logic             div_zero;

    logic             start;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic             nxt_q;
    logic [WIDTH-1:0] fin_res;
    logic             fin_exc;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   q_signed;

    assign start          = ctrl_MULT | ctrl_DIV;
    assign abs_a          = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b          = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign busy           = ((state == S_MULT) || (state == S_DIV)) && (cnt != CNT_FIN);
    assign data_resultRDY = (state == S_DONE);
    assign dbg_state      = state;

    // One multiply (Booth) or divide (restoring) step, plus the finalise values.
    always_comb begin
        m_ext     = {op_m[WIDTH-1], op_m};
        booth_sum = acc_hi;
        rem_sh    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial     = rem_sh - {1'b0, op_m};
        nxt_hi    = acc_hi;
        nxt_lo    = acc_lo;
        nxt_q     = booth_q;
        product   = {acc_hi[WIDTH-1:0], acc_lo};
        prod_top  = product[2*WIDTH-1:WIDTH-1];
        q_signed  = neg_q ? -acc_lo : acc_lo;
        fin_res   = '0;
        fin_exc   = 1'b0;

        if (state == S_MULT) begin
            case ({acc_lo[0], booth_q})
                2'b01:   booth_sum = acc_hi + m_ext;
                2'b10:   booth_sum = acc_hi - m_ext;
                default: booth_sum = acc_hi;
            endcase
            nxt_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            nxt_lo  = {booth_sum[0], acc_lo[WIDTH-1:1]};
            nxt_q   = acc_lo[0];
            fin_res = product[WIDTH-1:0];
            fin_exc = ~((&prod_top) | ~(|prod_top));
        end else begin
            if (!trial[WIDTH]) begin
                nxt_hi = trial;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = rem_sh;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
            // A positive quotient of magnitude 2^(WIDTH-1) only comes from INT_MIN / -1.
            if (div_zero || (!neg_q && acc_lo[WIDTH-1])) begin
                fin_res = '0;
                fin_exc = 1'b1;
            end else begin
                fin_res = q_signed;
                fin_exc = 1'b0;
            end
        end
    end

    // Sequencer: accept or restart ops, iterate, finalise, and pulse DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            booth_q        <= 1'b0;
            op_m           <= '0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            state    <= ctrl_MULT ? S_MULT : S_DIV;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= ctrl_MULT ? data_operandA : abs_a;
            op_m     <= ctrl_MULT ? data_operandB : abs_b;
            booth_q  <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
        end else begin
            case (state)
                S_MULT, S_DIV: begin
                    if (cnt != CNT_FIN) begin
                        acc_hi  <= nxt_hi;
                        acc_lo  <= nxt_lo;
                        booth_q <= nxt_q;
                        cnt     <= cnt + 1'b1;
                    end else begin
                        data_result    <= fin_res;
                        data_exception <= fin_exc;
                        state          <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
